// File: rtl/obj_sprite_engine_pkg.sv
// Shared definitions for the object sprite engine and the stage FSMs.
//  - slot_state_e : per-slot lifecycle encoding
//  - game_state_e : top-level game states
//  - find_code_e  : what the current stage asks the player to find
//  - slot_cfg_t   : one slot's runtime configuration (position + atlas source)
//  - s1_t         : per-slot first-stage render result
package obj_sprite_engine_pkg;

  localparam int COORD_W = 10;  // logical coordinate width inside the pipe
  localparam int POS_W   = 9;   // configured position / source width

  typedef enum logic [1:0] {
    SLOT_HIDDEN = 2'd0,
    SLOT_SHOWN  = 2'd1,
    SLOT_BLINK  = 2'd2
  } slot_state_e;

  typedef enum logic [2:0] {
    GS_TITLE  = 3'd0,
    GS_STAGE1 = 3'd1,
    GS_STAGE2 = 3'd2,
    GS_STAGE3 = 3'd3,
    GS_CLEAR  = 3'd4,
    GS_FAIL   = 3'd5
  } game_state_e;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    FIND_KEY   = 2'd1,
    FIND_LIGHT = 2'd2,
    FIND_DOOR  = 2'd3
  } find_code_e;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [POS_W-1:0] src_x;
    logic [POS_W-1:0] src_y;
  } slot_cfg_t;

  // tx/ty are already offset into the atlas: (x - X + src_x), (y - Y + src_y)
  typedef struct packed {
    logic               hit;
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
  } s1_t;

endpackage

// File: rtl/obj_slot.sv
// One object slot: configuration registers, HIDDEN/SHOWN/BLINK lifecycle,
// blink frame counter and the first render stage (hit test + atlas offsets).
// Ports:
//  clk, rst       : clock, async active-high reset
//  frame_start    : one-cycle pulse per frame
//  cfg_we, cfg,   : configuration write already decoded for this slot
//  cfg_show
//  collect_acc    : an accepted collect for this slot
//  pix_x, pix_y   : logical pixel coordinates
//  state          : current lifecycle state
//  fin            : combinational, BLINK ends at this clock edge
//  s1_q           : registered hit flag and atlas offsets
module obj_slot
  import obj_sprite_engine_pkg::*;
#(
  parameter int OBJ_W        = 20,
  parameter int OBJ_H        = 20,
  parameter int BLINK_FRAMES = 32,
  parameter int BLINK_HALF   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               cfg_we,
  input  slot_cfg_t          cfg,
  input  logic               cfg_show,
  input  logic               collect_acc,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output slot_state_e        state,
  output logic               fin,
  output s1_t                s1_q
);

  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  slot_cfg_t          cfg_q, cfg_d;
  slot_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  s1_t                s1_d;
  logic               visible;
  logic [COORD_W-1:0] x0, y0, dx, dy;

  // Lifecycle. A config write always wins: it overrides a same-cycle collect
  // and aborts a running blink without reporting completion.
  always_comb begin
    cfg_d   = cfg_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    if (cfg_we) begin
      cfg_d   = cfg;
      state_d = cfg_show ? SLOT_SHOWN : SLOT_HIDDEN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SLOT_SHOWN: if (collect_acc) begin
          state_d = SLOT_BLINK;
          cnt_d   = '0;
        end
        SLOT_BLINK: if (frame_start) begin
          if (cnt_q == CNT_LAST) begin
            state_d = SLOT_HIDDEN;
            cnt_d   = '0;
            fin     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Hit test in 10-bit arithmetic so an edge near 511 does not wrap.
  always_comb begin
    visible = (state_q == SLOT_SHOWN) ||
              ((state_q == SLOT_BLINK) &&
               (((32'(cnt_q) / 32'(BLINK_HALF)) % 32'd2) == 32'd0));
    x0      = {1'b0, cfg_q.x};
    y0      = {1'b0, cfg_q.y};
    dx      = pix_x - x0;
    dy      = pix_y - y0;
    s1_d.hit = visible &&
               (pix_x >= x0) && (pix_x < x0 + COORD_W'(OBJ_W)) &&
               (pix_y >= y0) && (pix_y < y0 + COORD_W'(OBJ_H));
    s1_d.tx  = dx + {1'b0, cfg_q.src_x};
    s1_d.ty  = dy + {1'b0, cfg_q.src_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= '0;
      state_q <= SLOT_HIDDEN;
      cnt_q   <= '0;
      s1_q    <= '0;
    end else begin
      cfg_q   <= cfg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/obj_sprite_engine.sv
// Object sprite engine: draws up to NUM_OBJ rectangular sprites from a shared
// texture atlas onto the VGA scan, with per-slot collect/blink lifecycle.
// Ports:
//  clk, rst            : pixel clock, async active-high reset
//  frame_start         : one-cycle pulse per frame
//  h_cnt, v_cnt        : VGA counters (scaled down by SCALE_SHIFT)
//  cfg_*               : slot configuration write
//  collect_valid/idx   : collect request; collect_ready = accepted this cycle
//  obj_done/done_idx   : one-cycle completion pulse per finished blink
//  pixel_addr, is_object, obj_id : render result, 2 cycles after h/v
module obj_sprite_engine
  import obj_sprite_engine_pkg::*;
#(
  parameter int NUM_OBJ      = 4,
  parameter int IDX_W        = 2,
  parameter int SCALE_SHIFT  = 1,
  parameter int OBJ_W        = 20,
  parameter int OBJ_H        = 20,
  parameter int ATLAS_W      = 320,
  parameter int ATLAS_DEPTH  = 76800,
  parameter int ADDR_W       = 17,
  parameter int BLINK_FRAMES = 32,
  parameter int BLINK_HALF   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [8:0]        cfg_x,
  input  logic [8:0]        cfg_y,
  input  logic [8:0]        cfg_src_x,
  input  logic [8:0]        cfg_src_y,
  input  logic              cfg_show,
  input  logic              collect_valid,
  input  logic [IDX_W-1:0]  collect_idx,
  output logic              collect_ready,
  output logic              obj_done,
  output logic [IDX_W-1:0]  done_idx,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              is_object,
  output logic [IDX_W-1:0]  obj_id
);

  logic [COORD_W-1:0] pix_x, pix_y;
  slot_cfg_t          cfg_bus;
  slot_state_e        state [NUM_OBJ];
  logic [NUM_OBJ-1:0] cfg_sel, acc_sel, fin_vec;
  s1_t [NUM_OBJ-1:0]  s1;

  assign pix_x   = h_cnt >> SCALE_SHIFT;
  assign pix_y   = v_cnt >> SCALE_SHIFT;
  assign cfg_bus = '{x: cfg_x, y: cfg_y, src_x: cfg_src_x, src_y: cfg_src_y};

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_slot
    assign cfg_sel[i] = cfg_we && (cfg_idx == IDX_W'(i));
    assign acc_sel[i] = collect_ready && (collect_idx == IDX_W'(i));
    obj_slot #(
      .OBJ_W(OBJ_W), .OBJ_H(OBJ_H),
      .BLINK_FRAMES(BLINK_FRAMES), .BLINK_HALF(BLINK_HALF)
    ) u_slot (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .cfg_we(cfg_sel[i]), .cfg(cfg_bus), .cfg_show(cfg_show),
      .collect_acc(acc_sel[i]), .pix_x(pix_x), .pix_y(pix_y),
      .state(state[i]), .fin(fin_vec[i]), .s1_q(s1[i])
    );
  end

  // Only a SHOWN slot that is not being reconfigured this cycle accepts.
  always_comb begin
    collect_ready = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++)
      if (collect_idx == IDX_W'(i) && state[i] == SLOT_SHOWN && !cfg_sel[i])
        collect_ready = collect_valid;
  end

  // Stage 2: lowest-index hit owns the pixel; no hit leaves everything 0.
  logic               is_object_q, is_object_d;
  logic [IDX_W-1:0]   obj_id_q, obj_id_d;
  logic [ADDR_W-1:0]  pixel_addr_q, pixel_addr_d;
  logic [COORD_W-1:0] sel_tx, sel_ty;
  logic [31:0]        lin;

  always_comb begin
    is_object_d = 1'b0;
    obj_id_d    = '0;
    sel_tx      = '0;
    sel_ty      = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--)
      if (s1[i].hit) begin
        is_object_d = 1'b1;
        obj_id_d    = IDX_W'(i);
        sel_tx      = s1[i].tx;
        sel_ty      = s1[i].ty;
      end
    lin          = 32'(sel_tx) + 32'(sel_ty) * 32'(ATLAS_W);
    pixel_addr_d = ADDR_W'(lin % 32'(ATLAS_DEPTH));
  end

  // Completion arbiter: slots finishing together are reported one per
  // cycle, lowest index first; the rest wait in the pending mask.
  logic [NUM_OBJ-1:0] pend_q, pend_d, cand;
  logic               obj_done_q, obj_done_d;
  logic [IDX_W-1:0]   done_idx_q, done_idx_d;

  always_comb begin
    cand       = pend_q | fin_vec;
    pend_d     = cand;
    obj_done_d = 1'b0;
    done_idx_d = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--)
      if (cand[i]) begin
        obj_done_d = 1'b1;
        done_idx_d = IDX_W'(i);
      end
    if (obj_done_d) pend_d[done_idx_d] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_object_q  <= 1'b0;
      obj_id_q     <= '0;
      pixel_addr_q <= '0;
      pend_q       <= '0;
      obj_done_q   <= 1'b0;
      done_idx_q   <= '0;
    end else begin
      is_object_q  <= is_object_d;
      obj_id_q     <= obj_id_d;
      pixel_addr_q <= pixel_addr_d;
      pend_q       <= pend_d;
      obj_done_q   <= obj_done_d;
      done_idx_q   <= done_idx_d;
    end
  end

  assign is_object  = is_object_q;
  assign obj_id     = obj_id_q;
  assign pixel_addr = pixel_addr_q;
  assign obj_done   = obj_done_q;
  assign done_idx   = done_idx_q;

endmodule

// File: tb/tb_obj_sprite_engine.sv
// Self-checking bench for obj_sprite_engine: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of slots, blink timing and the completion queue.
module tb_obj_sprite_engine;

  localparam int NUM_OBJ = 4, IDX_W = 2, SCALE_SHIFT = 1;
  localparam int OBJ_W = 20, OBJ_H = 20, ATLAS_W = 320, ATLAS_DEPTH = 76800;
  localparam int ADDR_W = 17, BLINK_FRAMES = 32, BLINK_HALF = 4;

  logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0;
  logic [9:0] h_cnt = '0, v_cnt = '0;
  logic cfg_we = 1'b0, cfg_show = 1'b0, collect_valid = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0, collect_idx = '0;
  logic [8:0] cfg_x = '0, cfg_y = '0, cfg_src_x = '0, cfg_src_y = '0;
  logic collect_ready, obj_done, is_object;
  logic [IDX_W-1:0] done_idx, obj_id;
  logic [ADDR_W-1:0] pixel_addr;

  obj_sprite_engine #(
    .NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W), .SCALE_SHIFT(SCALE_SHIFT),
    .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .ATLAS_W(ATLAS_W), .ATLAS_DEPTH(ATLAS_DEPTH),
    .ADDR_W(ADDR_W), .BLINK_FRAMES(BLINK_FRAMES), .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_src_x(cfg_src_x), .cfg_src_y(cfg_src_y), .cfg_show(cfg_show),
    .collect_valid(collect_valid), .collect_idx(collect_idx),
    .collect_ready(collect_ready), .obj_done(obj_done), .done_idx(done_idx),
    .pixel_addr(pixel_addr), .is_object(is_object), .obj_id(obj_id)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_st: 0 hidden, 1 shown, 2 blinking; m_cnt: frames seen since collect
  int m_st [NUM_OBJ], m_x [NUM_OBJ], m_y [NUM_OBJ];
  int m_sx [NUM_OBJ], m_sy [NUM_OBJ], m_cnt [NUM_OBJ];
  int m_q [$];
  int r_obj, r_id, r_addr;          // render result sampled one edge ago
  int e_obj, e_id, e_addr, e_done, e_didx;

  function automatic bit m_vis(input int i);
    return m_st[i] == 1 || (m_st[i] == 2 && ((m_cnt[i] / BLINK_HALF) % 2) == 0);
  endfunction

  function automatic int m_ready();
    if (!collect_valid) return 0;
    if (cfg_we && cfg_idx == collect_idx) return 0;
    return (m_st[int'(collect_idx)] == 1) ? 1 : 0;
  endfunction

  task automatic m_render(input int hx, input int vy, output int o, output int id,
                          output int a);
    int x, y;
    x = hx >> SCALE_SHIFT;
    y = vy >> SCALE_SHIFT;
    o = 0; id = 0; a = 0;
    for (int i = 0; i < NUM_OBJ; i++)
      if (o == 0 && m_vis(i) && x >= m_x[i] && x < m_x[i] + OBJ_W &&
          y >= m_y[i] && y < m_y[i] + OBJ_H) begin
        o = 1; id = i;
        a = ((x - m_x[i] + m_sx[i]) + (y - m_y[i] + m_sy[i]) * ATLAS_W) % ATLAS_DEPTH;
      end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_OBJ; i++) begin
      m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0;
    end
    m_q.delete();
    r_obj = 0; r_id = 0; r_addr = 0;
    e_obj = 0; e_id = 0; e_addr = 0; e_done = 0; e_didx = 0;
  endtask

  task automatic m_step();
    int acc;
    acc = m_ready();
    e_obj = r_obj; e_id = r_id; e_addr = r_addr;
    m_render(int'(h_cnt), int'(v_cnt), r_obj, r_id, r_addr);
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (cfg_we && int'(cfg_idx) == i) begin
        m_x[i] = int'(cfg_x); m_y[i] = int'(cfg_y);
        m_sx[i] = int'(cfg_src_x); m_sy[i] = int'(cfg_src_y);
        m_st[i] = cfg_show ? 1 : 0; m_cnt[i] = 0;
      end else if (m_st[i] == 1 && acc == 1 && int'(collect_idx) == i) begin
        m_st[i] = 2; m_cnt[i] = 0;
      end else if (m_st[i] == 2 && frame_start) begin
        if (m_cnt[i] == BLINK_FRAMES - 1) begin
          m_st[i] = 0; m_q.push_back(i);
        end else m_cnt[i]++;
      end
    end
    if (m_q.size() > 0) begin e_done = 1; e_didx = m_q.pop_front(); end
    else begin e_done = 0; e_didx = 0; end
  endtask

  // Compare process: collect_ready mid-cycle, registered outputs 1ns after edge.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst) chk("m_collect_ready", int'(collect_ready), m_ready());
      @(posedge clk);
      if (rst) m_reset();
      else m_step();
      #1;
      chk("m_is_object", int'(is_object), e_obj);
      chk("m_obj_id", int'(obj_id), e_id);
      chk("m_pixel_addr", int'(pixel_addr), e_addr);
      chk("m_obj_done", int'(obj_done), e_done);
      if (e_done == 1) chk("m_done_idx", int'(done_idx), e_didx);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_cfg(input int idx, input int x, input int y, input int sx,
                        input int sy, input int show);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_x = 9'(x); cfg_y = 9'(y);
    cfg_src_x = 9'(sx); cfg_src_y = 9'(sy); cfg_show = (show != 0);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic scan(input int h, input int v);
    h_cnt = 10'(h); v_cnt = 10'(v);
    idle(2);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic collect(input int idx, input int exp_ready);
    collect_valid = 1'b1; collect_idx = IDX_W'(idx);
    #1 chk("collect_ready", int'(collect_ready), exp_ready);
    tick();
    collect_valid = 1'b0;
  endtask

  initial begin
    int fcnt;
    idle(3);
    chk("rst_is_object", int'(is_object), 0);
    chk("rst_pixel_addr", int'(pixel_addr), 0);
    chk("rst_obj_done", int'(obj_done), 0);
    chk("rst_done_idx", int'(done_idx), 0);
    rst = 1'b0;
    idle(1);

    // basic draw and right-edge exclusion
    do_cfg(0, 65, 35, 0, 80, 1);
    scan(130, 70);
    chk("draw_is_object", int'(is_object), 1);
    chk("draw_obj_id", int'(obj_id), 0);
    chk("draw_addr", int'(pixel_addr), 25600);
    scan(170, 70);
    chk("edge_is_object", int'(is_object), 0);
    chk("edge_addr", int'(pixel_addr), 0);

    // overlap priority
    do_cfg(0, 100, 100, 0, 0, 1);
    do_cfg(1, 100, 100, 20, 0, 1);
    scan(200, 200);
    chk("ovl_obj_id", int'(obj_id), 0);
    do_cfg(0, 100, 100, 0, 0, 0);
    idle(2);
    chk("ovl_hide_obj_id", int'(obj_id), 1);
    chk("ovl_hide_addr", int'(pixel_addr), 20);

    // collect slot 2 and follow the blink
    do_cfg(2, 10, 10, 40, 0, 1);
    scan(20, 20);
    collect(2, 1);
    idle(3);
    chk("blink_f0", int'(is_object), 1);
    for (int p = 1; p <= BLINK_FRAMES; p++) begin
      frame();
      if (p == BLINK_FRAMES) begin
        chk("blink_done", int'(obj_done), 1);
        chk("blink_done_idx", int'(done_idx), 2);
        idle(3);
        chk("blink_hidden", int'(is_object), 0);
      end else begin
        idle(3);
        chk("blink_vis", int'(is_object), ((p / 4) % 2 == 0) ? 1 : 0);
      end
    end
    collect(2, 0);

    // cfg write beats a collect to the same slot
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_x = 9'd200; cfg_y = 9'd50;
    cfg_src_x = 9'd0; cfg_src_y = 9'd0; cfg_show = 1'b1;
    collect(1, 0);
    cfg_we = 1'b0;
    scan(400, 100);
    chk("cfgwin_is_object", int'(is_object), 1);
    chk("cfgwin_obj_id", int'(obj_id), 1);
    repeat (4) begin frame(); idle(5); end
    chk("cfgwin_no_blink", int'(is_object), 1);

    // two slots finishing on the same frame
    do_cfg(0, 10, 150, 0, 0, 1);
    do_cfg(3, 30, 150, 0, 0, 1);
    collect(0, 1);
    collect(3, 1);
    repeat (BLINK_FRAMES - 1) begin frame(); idle(6); end
    frame();
    chk("dual_done0", int'(obj_done), 1);
    chk("dual_idx0", int'(done_idx), 0);
    tick();
    chk("dual_done1", int'(obj_done), 1);
    chk("dual_idx1", int'(done_idx), 3);
    tick();
    chk("dual_done_end", int'(obj_done), 0);

    // async reset in the middle of a blink
    do_cfg(1, 50, 50, 0, 0, 1);
    collect(1, 1);
    repeat (8) begin frame(); idle(6); end
    scan(100, 100);
    chk("prerst_is_object", int'(is_object), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_is_object", int'(is_object), 0);
    chk("arst_obj_id", int'(obj_id), 0);
    chk("arst_addr", int'(pixel_addr), 0);
    tick();
    rst = 1'b0;
    repeat (30) begin
      frame();
      chk("postrst_no_done", int'(obj_done), 0);
      idle(6);
    end
    chk("postrst_hidden", int'(is_object), 0);

    // right edge near 511 must not wrap; atlas address wraps modulo depth
    do_cfg(2, 500, 2, 7, 9, 1);
    scan(1023, 4);
    chk("hiedge_is_object", int'(is_object), 1);
    chk("hiedge_obj_id", int'(obj_id), 2);
    chk("hiedge_addr", int'(pixel_addr), 2898);
    scan(998, 4);
    chk("hiedge_left", int'(is_object), 0);
    do_cfg(2, 0, 0, 5, 250, 1);
    scan(6, 38);
    chk("wrap_addr", int'(pixel_addr), 9288);

    // randomized traffic
    for (int i = 0; i < NUM_OBJ; i++)
      do_cfg(i, 100 + 10 * i, 100 + 8 * i, $urandom_range(511, 0), $urandom_range(511, 0), 1);
    fcnt = 0;
    repeat (6000) begin
      frame_start = (fcnt == 0);
      fcnt = frame_start ? $urandom_range(9, 6) : fcnt - 1;
      cfg_we = ($urandom_range(199, 0) == 0);
      cfg_idx = IDX_W'($urandom_range(NUM_OBJ - 1, 0));
      cfg_x = ($urandom_range(7, 0) == 0) ? 9'($urandom_range(511, 490)) : 9'($urandom_range(140, 100));
      cfg_y = ($urandom_range(7, 0) == 0) ? 9'($urandom_range(511, 490)) : 9'($urandom_range(140, 100));
      cfg_src_x = 9'($urandom_range(511, 0));
      cfg_src_y = 9'($urandom_range(511, 0));
      cfg_show = ($urandom_range(3, 0) != 0);
      collect_valid = ($urandom_range(3, 0) == 0);
      collect_idx = IDX_W'($urandom_range(NUM_OBJ - 1, 0));
      if ($urandom_range(9, 0) == 0) begin
        h_cnt = 10'($urandom_range(1023, 0));
        v_cnt = 10'($urandom_range(1023, 0));
      end else begin
        h_cnt = 10'($urandom_range(330, 190));
        v_cnt = 10'($urandom_range(330, 190));
      end
      tick();
    end
    frame_start = 1'b0; cfg_we = 1'b0; collect_valid = 1'b0;
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/obj_sprite_engine.md
Name: obj_sprite_engine

Overview:
- Parametrised successor to the per-stage object drawer: renders up to NUM_OBJ rectangular sprites (keys, lights, doors) from a shared texture atlas onto the VGA scan.
- Each object slot has a runtime-configurable screen position, atlas source, and a lifecycle state machine: HIDDEN, SHOWN, BLINK. Collecting an object makes it blink for a fixed number of frames before it disappears.
- Sits between the VGA controller counters and the atlas block-memory address mux; the top-level game FSM writes slot configuration and issues collect requests.

Parameters:
- NUM_OBJ, 4, number of object slots (1..8).
- IDX_W, 2, slot index width, equal to clog2(NUM_OBJ), minimum 1.
- SCALE_SHIFT, 1, logical pixel coordinate = counter >> SCALE_SHIFT.
- OBJ_W, 20, sprite width in logical pixels.
- OBJ_H, 20, sprite height in logical pixels.
- ATLAS_W, 320, atlas row pitch in texels.
- ATLAS_DEPTH, 76800, atlas size in texels; addresses wrap modulo this value.
- ADDR_W, 17, atlas address width.
- BLINK_FRAMES, 32, length of the BLINK state in frames.
- BLINK_HALF, 4, frames per on or off blink phase.

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge)
- h_cnt  in  10  VGA horizontal counter
- v_cnt  in  10  VGA vertical counter
- cfg_we  in  1  slot configuration write strobe
- cfg_idx  in  IDX_W  slot being configured
- cfg_x  in  9  sprite left edge, logical pixels
- cfg_y  in  9  sprite top edge, logical pixels
- cfg_src_x  in  9  atlas source column
- cfg_src_y  in  9  atlas source row
- cfg_show  in  1  1 = slot goes to SHOWN, 0 = slot goes to HIDDEN
- collect_valid  in  1  request to collect slot collect_idx
- collect_idx  in  IDX_W  slot to collect
- collect_ready  out  1  collect request is accepted this cycle
- obj_done  out  1  one-cycle pulse when a slot finishes BLINK
- done_idx  out  IDX_W  slot that finished, valid while obj_done is high
- pixel_addr  out  ADDR_W  atlas address for the current pixel
- is_object  out  1  the current pixel belongs to a visible sprite
- obj_id  out  IDX_W  slot that owns the current pixel

Behaviour:
- Reset (asynchronous): all slots HIDDEN; all slot registers, blink counters and frame toggles cleared to 0; every output 0.
- Logical coordinates: x = h_cnt >> SCALE_SHIFT, y = v_cnt >> SCALE_SHIFT.
- Render pipeline, 2-cycle latency from h_cnt/v_cnt to outputs:
  - S1 registers a per-slot hit vector, x - cfg_x and y - cfg_y.
  - Hit condition: visible, x >= X, x < X+OBJ_W, y >= Y, y < Y+OBJ_H. Comparisons use 10-bit arithmetic, so X+OBJ_W > 511 does not wrap.
  - S2 selects the lowest-index hit (priority encoder) and registers pixel_addr = ((x-X+src_x) + (y-Y+src_y)*ATLAS_W) mod ATLAS_DEPTH.
  - When there is no hit: is_object = 0, pixel_addr = 0, obj_id = 0.
- Visibility: SHOWN is always visible. BLINK is visible when (blink_cnt / BLINK_HALF) is even. HIDDEN is never visible.
- Slot state machine:
  - HIDDEN or SHOWN, on cfg_we: go to SHOWN if cfg_show, else HIDDEN.
  - SHOWN, on an accepted collect: go to BLINK with blink_cnt = 0.
  - BLINK: blink_cnt increments on each frame_start. When it reaches BLINK_FRAMES-1 and another frame_start arrives, go to HIDDEN and pulse obj_done/done_idx on the next cycle.
- collect_ready is combinational: high only if the target slot is SHOWN and cfg_we does not hit the same slot this cycle. A collect aimed at a HIDDEN or BLINK slot gets ready = 0 and has no effect.
- Simultaneous events:
  - cfg_we and collect on the same slot: cfg_we wins and the collect is dropped.
  - cfg_we on a slot in BLINK: the blink is aborted, no obj_done, and the slot is reloaded.
  - If several slots finish in the same frame: obj_done pulses on consecutive cycles, lowest index first, with a pending mask holding the rest.
- Config writes take effect at the S1 register on the next cycle; a mid-frame write can tear the sprite, which is acceptable.
- Reset mid-BLINK: the slot is HIDDEN immediately and no obj_done is produced.

Decomposition:
- Shared package holds:
  - slot state encoding (HIDDEN=0, SHOWN=1, BLINK=2);
  - the game-state constants (TITLE..FAIL) and find codes (NONE, FIND_KEY, FIND_LIGHT, FIND_DOOR) already used by the stage FSMs.
- One natural sub-module: obj_slot. It holds one slot's registers, state machine, blink counter and hit comparator, and is instantiated NUM_OBJ times. The top level keeps the priority encoder, address multiply/modulo, done arbiter and collect_ready.

Test Plan:
- Reset, then write slot 0 with (x=65, y=35, src=0,80, show=1), scan h=130, v=70 -> two cycles later is_object=1, obj_id=0, pixel_addr=25600; at h=170, v=70 -> is_object=0.
- Slots 0 and 1 overlapping at (100,100), scan h=200, v=200 -> obj_id=0; set slot 0 HIDDEN -> obj_id=1.
- Collect slot 2 while SHOWN -> collect_ready=1 and the slot enters BLINK. Visible in frames 0-3, hidden in frames 4-7, and so on. After 32 frame_starts -> obj_done=1, done_idx=2, slot HIDDEN; a repeat collect gets collect_ready=0.
- cfg_we and collect_valid to slot 1 in the same cycle -> collect_ready=0 and the slot takes the cfg values.
- Slots 0 and 3 in BLINK ending on the same frame_start -> obj_done pulses on two consecutive cycles with done_idx 0 then 3.
- Assert rst asynchronously mid-BLINK between clock edges -> all outputs 0 immediately, no obj_done after release.
